// File: rtl/detector_nota.sv
// Note detector: measures the period of a square wave and decodes one of 8 notes.
// Latency: a note decision is visible k+2 cycles after the edge-detect cycle D (D+9 on no match).
// Backpressure: none; the input is free-running and edges during a search restart it.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-low reset
//   enable      detection enable; low returns to IDLE and drops nota_valida
//   pulso_in    asynchronous square-wave input (synchronised internally)
//   nota        last confirmed note index 0..7
//   nota_valida high while a confirmed note is present
//   nova_nota   one-cycle pulse when nota becomes valid or changes
//   periodo     last measured period in clock cycles
module detector_nota #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int N_CONFIRM  = 3,
  parameter int TOL_SHIFT  = 5,
  parameter int MIN_FREQ   = 200,
  localparam int MAX_PERIOD = CLOCK_FREQ / MIN_FREQ,
  localparam int W          = $clog2(MAX_PERIOD + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         pulso_in,
  output logic [3:0]   nota,
  output logic         nota_valida,
  output logic         nova_nota,
  output logic [W-1:0] periodo
);

  // Nominal periods of the note table 264..528 Hz, in clock cycles.
  localparam int P0 = CLOCK_FREQ / 264;
  localparam int P1 = CLOCK_FREQ / 297;
  localparam int P2 = CLOCK_FREQ / 330;
  localparam int P3 = CLOCK_FREQ / 352;
  localparam int P4 = CLOCK_FREQ / 396;
  localparam int P5 = CLOCK_FREQ / 440;
  localparam int P6 = CLOCK_FREQ / 495;
  localparam int P7 = CLOCK_FREQ / 528;

  // Packed tables, element [k] holds note k.
  localparam logic [7:0][W-1:0] PERIOD_TAB = {
    W'(P7), W'(P6), W'(P5), W'(P4), W'(P3), W'(P2), W'(P1), W'(P0)
  };
  localparam logic [7:0][W-1:0] TOL_TAB = {
    W'(P7 >> TOL_SHIFT), W'(P6 >> TOL_SHIFT), W'(P5 >> TOL_SHIFT), W'(P4 >> TOL_SHIFT),
    W'(P3 >> TOL_SHIFT), W'(P2 >> TOL_SHIFT), W'(P1 >> TOL_SHIFT), W'(P0 >> TOL_SHIFT)
  };

  localparam logic [W-1:0]  MAX_CNT   = W'(MAX_PERIOD);
  localparam int            CW        = $clog2(N_CONFIRM + 1);
  localparam logic [CW-1:0] CONF_FULL = CW'(N_CONFIRM);
  localparam logic [CW-1:0] CONF_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    CLASSIFY = 2'd2
  } state_t;

  // --------------------------------------------------------------------
  // Input synchroniser and rising-edge detect
  // --------------------------------------------------------------------
  logic sync_q1;
  logic sync_q2;
  logic hist_q;
  logic edge_det;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync_q1 <= pulso_in;
      sync_q2 <= sync_q1;
      hist_q  <= sync_q2;
    end
  end

  assign edge_det = sync_q2 & ~hist_q;

  // --------------------------------------------------------------------
  // Period counter: restarts on every edge, saturates at MAX_PERIOD so a
  // silent input can be recognised.
  // --------------------------------------------------------------------
  logic [W-1:0] cnt_q;
  logic [W-1:0] period_meas;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (edge_det) begin
      cnt_q <= '0;
    end else if (cnt_q != MAX_CNT) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // The count started at 0 one cycle after the previous edge, so the period
  // is count+1. A saturated count is reported as MAX_PERIOD so the value
  // always fits in W bits.
  assign period_meas = (cnt_q == MAX_CNT) ? MAX_CNT : cnt_q + W'(1);

  // --------------------------------------------------------------------
  // Classifier datapath: one table entry per cycle
  // --------------------------------------------------------------------
  state_t       state_q;
  state_t       state_n;
  logic [2:0]   k_q;
  logic [2:0]   k_n;
  logic [2:0]   cand_q;
  logic [2:0]   cand_n;
  logic         cand_vld_q;
  logic         cand_vld_n;
  logic [CW-1:0] conf_q;
  logic [CW-1:0] conf_n;
  logic [CW-1:0] conf_inc;
  logic [CW-1:0] conf_new;
  logic [3:0]   nota_n;
  logic         valida_n;
  logic         nova_n;
  logic [W-1:0] periodo_n;

  logic [W-1:0] nom_per;
  logic [W-1:0] tol_per;
  logic [W-1:0] per_diff;
  logic         per_hit;

  assign nom_per  = PERIOD_TAB[k_q];
  assign tol_per  = TOL_TAB[k_q];
  // Larger minus smaller keeps the unsigned difference from wrapping.
  assign per_diff = (periodo >= nom_per) ? (periodo - nom_per) : (nom_per - periodo);
  assign per_hit  = (per_diff <= tol_per);

  assign conf_inc = (conf_q >= CONF_FULL) ? CONF_FULL : conf_q + CONF_ONE;

  // --------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cand_q      <= '0;
      cand_vld_q  <= 1'b0;
      conf_q      <= '0;
      nota        <= '0;
      nota_valida <= 1'b0;
      nova_nota   <= 1'b0;
      periodo     <= '0;
    end else begin
      state_q     <= state_n;
      k_q         <= k_n;
      cand_q      <= cand_n;
      cand_vld_q  <= cand_vld_n;
      conf_q      <= conf_n;
      nota        <= nota_n;
      nota_valida <= valida_n;
      nova_nota   <= nova_n;
      periodo     <= periodo_n;
    end
  end

  // --------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------
  always_comb begin
    state_n    = state_q;
    k_n        = k_q;
    cand_n     = cand_q;
    cand_vld_n = cand_vld_q;
    conf_n     = conf_q;
    conf_new   = conf_q;
    nota_n     = nota;
    valida_n   = nota_valida;
    nova_n     = 1'b0;
    periodo_n  = periodo;

    if (!enable) begin
      // Clearing the candidate forces a full confirmation run after re-enable.
      state_n    = IDLE;
      valida_n   = 1'b0;
      cand_vld_n = 1'b0;
      conf_n     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // The first edge only starts a measurement; there is no period yet.
          if (edge_det) begin
            state_n = MEASURE;
          end
        end

        MEASURE: begin
          if (edge_det) begin
            periodo_n = period_meas;
            k_n       = '0;
            state_n   = CLASSIFY;
          end else if (cnt_q == MAX_CNT) begin
            // Silence: no edge within the longest period of interest.
            state_n    = IDLE;
            valida_n   = 1'b0;
            cand_vld_n = 1'b0;
            conf_n     = '0;
          end
        end

        CLASSIFY: begin
          if (edge_det) begin
            // A new period closed before the search finished: treat the old
            // one as unmatched and restart on the fresh measurement.
            periodo_n  = period_meas;
            k_n        = '0;
            cand_vld_n = 1'b0;
            conf_n     = '0;
            valida_n   = 1'b0;
          end else if (per_hit) begin
            state_n = MEASURE;
            if (cand_vld_q && (cand_q == k_q)) begin
              conf_new = conf_inc;
            end else begin
              conf_new = CONF_ONE;
            end
            cand_n     = k_q;
            cand_vld_n = 1'b1;
            conf_n     = conf_new;
            // Pulse only on a real change so a held note stays quiet.
            if ((conf_new == CONF_FULL) &&
                (!nota_valida || (nota != {1'b0, k_q}))) begin
              nota_n   = {1'b0, k_q};
              valida_n = 1'b1;
              nova_n   = 1'b1;
            end
          end else if (k_q == 3'd7) begin
            state_n    = MEASURE;
            cand_vld_n = 1'b0;
            conf_n     = '0;
            valida_n   = 1'b0;
          end else begin
            k_n = k_q + 3'd1;
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detector_nota.sv
// Bench for detector_nota: directed note scenarios plus random square waves,
// compared every cycle against a timestamp-based behavioural model.
module tb_detector_nota;

  localparam int CF   = 10_000;
  localparam int NC   = 3;
  localparam int MAXP = CF / 200;
  localparam int W    = $clog2(MAXP + 1);

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         pulso_in;
  logic [3:0]   nota;
  logic         nota_valida;
  logic         nova_nota;
  logic [W-1:0] periodo;

  detector_nota #(.CLOCK_FREQ(CF), .N_CONFIRM(NC), .TOL_SHIFT(5), .MIN_FREQ(200)) dut (
    .clock(clock), .reset(reset), .enable(enable), .pulso_in(pulso_in),
    .nota(nota), .nota_valida(nota_valida), .nova_nota(nova_nota), .periodo(periodo)
  );

  initial forever #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int nova_cnt = 0;
  int last_nova_cyc = 0;
  int last_rise_cyc = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Note table from the frequencies, independent of the design's tables.
  function automatic int nom(input int k);
    int f;
    case (k)
      0: f = 264; 1: f = 297; 2: f = 330; 3: f = 352;
      4: f = 396; 5: f = 440; 6: f = 495; default: f = 528;
    endcase
    return CF / f;
  endfunction

  function automatic int match_idx(input int per);
    for (int k = 0; k < 8; k++) begin
      int d;
      d = (per > nom(k)) ? per - nom(k) : nom(k) - per;
      if (d <= (nom(k) >> 5)) return k;
    end
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  int m_nota = 0, m_valid = 0, m_nova = 0, m_per = 0;
  int cand = -1, conf = 0;
  bit active = 0, srch = 0;
  int srch_done = 0, srch_k = -1, last_edge = 0, mc = 0;
  bit h0 = 0, h1 = 0, h2 = 0;

  task automatic decide(input int k);
    if (k < 0) begin
      cand = -1; conf = 0; m_valid = 0;
    end else begin
      if (cand == k) conf = (conf + 1 > NC) ? NC : conf + 1;
      else begin cand = k; conf = 1; end
      if (conf == NC && (m_valid == 0 || m_nota != k)) begin
        m_nota = k; m_valid = 1; m_nova = 1;
      end
    end
  endtask

  // Period = cycles since previous edge, capped at MAXP; decision lands on the
  // cycle that compares the matching index (index 7 if nothing matches).
  task automatic start_search(input int c);
    m_per = (c - last_edge > MAXP) ? MAXP : c - last_edge;
    srch_k = match_idx(m_per);
    srch_done = (srch_k >= 0) ? c + 1 + srch_k : c + 8;
    srch = 1;
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_nota = 0; m_valid = 0; m_nova = 0; m_per = 0;
      cand = -1; conf = 0; active = 0; srch = 0;
      h0 = 0; h1 = 0; h2 = 0; last_edge = mc;
    end else begin
      bit rise;
      rise = h1 & ~h2;          // edge seen in the cycle ending now
      h2 = h1; h1 = h0; h0 = pulso_in;
      m_nova = 0;
      if (!enable) begin
        active = 0; srch = 0; m_valid = 0; cand = -1; conf = 0;
      end else if (!active) begin
        if (rise) active = 1;
      end else if (srch) begin
        if (rise) begin decide(-1); start_search(mc); end
        else if (mc == srch_done) begin decide(srch_k); srch = 0; end
      end else begin
        if (rise) start_search(mc);
        else if (mc - last_edge - 1 >= MAXP) begin
          active = 0; m_valid = 0; cand = -1; conf = 0;
        end
      end
      if (rise) last_edge = mc;
      mc++;
    end
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Per-cycle comparison on the falling edge.
  initial forever begin
    @(negedge clock);
    if (cmp_on) begin
      chk("nota", int'(nota), m_nota);
      chk("nota_valida", int'(nota_valida), m_valid);
      chk("nova_nota", int'(nova_nota), m_nova);
      chk("periodo", int'(periodo), m_per);
      if (nova_nota) begin nova_cnt++; last_nova_cyc = cyc; end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_period(input int p, input int hi);
    pulso_in = 1'b1;
    last_rise_cyc = cyc;
    repeat (hi) tick();
    pulso_in = 1'b0;
    repeat (p - hi) tick();
  endtask

  task automatic run_note(input int p, input int n);
    for (int i = 0; i < n; i++) drive_period(p, p / 2);
  endtask

  int base;
  int gl[9] = '{33, 33, 10, 33, 10, 33, 33, 33, 33};

  initial begin
    reset = 1'b1; enable = 1'b0; pulso_in = 1'b0;
    #1 reset = 1'b0;
    cmp_on = 1'b1;
    repeat (3) tick();
    chk("rst_nota", int'(nota), 0);
    chk("rst_valida", int'(nota_valida), 0);
    chk("rst_nova", int'(nova_nota), 0);
    chk("rst_periodo", int'(periodo), 0);
    reset = 1'b1; enable = 1'b1;
    tick();

    // Period 22: confirmed after the 4th rising edge, visible 9 cycles after the rise is driven.
    base = nova_cnt;
    for (int i = 0; i < 6; i++) begin
      drive_period(22, 11);
      if (i == 3) begin
        chk("nova_delay_22", last_nova_cyc - last_rise_cyc, 9);
        chk("nova_cnt_22_at4", nova_cnt - base, 1);
      end
    end
    chk("nova_cnt_22_after6", nova_cnt - base, 1);
    chk("nota_22", int'(nota), 5);
    chk("valida_22", int'(nota_valida), 1);
    chk("periodo_22", int'(periodo), 22);

    // Period 38 sits inside note 0's tolerance window.
    base = nova_cnt;
    run_note(38, 5);
    chk("nota_38", int'(nota), 0);
    chk("valida_38", int'(nota_valida), 1);
    chk("nova_cnt_38", nova_cnt - base, 1);

    // Period 35 matches nothing.
    base = nova_cnt;
    run_note(35, 6);
    chk("valida_35", int'(nota_valida), 0);
    chk("periodo_35", int'(periodo), 35);
    chk("nova_cnt_35", nova_cnt - base, 0);

    // Note 5 held, then switch to 18: old note persists until 3 clean 18s.
    run_note(22, 5);
    base = nova_cnt;
    run_note(18, 3);
    chk("nota_hold5", int'(nota), 5);
    chk("valida_hold5", int'(nota_valida), 1);
    run_note(18, 1);
    chk("nota_18", int'(nota), 7);
    chk("nova_cnt_18", nova_cnt - base, 1);

    // Note 2, then silence, then restart.
    run_note(30, 5);
    chk("nota_30", int'(nota), 2);
    base = nova_cnt;
    repeat (60) tick();
    chk("valida_silence", int'(nota_valida), 0);
    chk("nota_silence", int'(nota), 2);
    chk("nova_cnt_silence", nova_cnt - base, 0);
    run_note(30, 3);
    chk("valida_restart3", int'(nota_valida), 0);
    run_note(30, 1);
    chk("valida_restart4", int'(nota_valida), 1);

    // Period 33 with glitch periods of 10.
    for (int i = 0; i < 9; i++) begin
      drive_period(gl[i], gl[i] / 2);
      if (i == 7) chk("valida_glitch", int'(nota_valida), 0);
    end
    chk("nota_33", int'(nota), 1);
    chk("valida_33", int'(nota_valida), 1);

    // Reset while the classifier is searching.
    pulso_in = 1'b1;
    repeat (3) tick();
    chk("valida_pre_reset", int'(nota_valida), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_nota", int'(nota), 0);
    chk("midrst_valida", int'(nota_valida), 0);
    chk("midrst_nova", int'(nova_nota), 0);
    chk("midrst_periodo", int'(periodo), 0);
    tick();
    pulso_in = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Enable dropped while a note is valid.
    run_note(25, 5);
    chk("nota_25", int'(nota), 4);
    enable = 1'b0;
    tick();
    chk("dis_valida", int'(nota_valida), 0);
    chk("dis_nota", int'(nota), 4);
    run_note(25, 2);
    enable = 1'b1;
    base = nova_cnt;
    run_note(25, 3);
    chk("reen_valida3", int'(nota_valida), 0);
    run_note(25, 1);
    chk("reen_valida4", int'(nota_valida), 1);
    chk("reen_nova_cnt", nova_cnt - base, 1);

    // Random square waves, silences and enable drops.
    for (int it = 0; it < 200; it++) begin
      int r, p, n;
      r = $urandom_range(0, 99);
      if (r < 6) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 20)) tick();
        enable = 1'b1;
      end else if (r < 10) begin
        pulso_in = 1'b0;
        repeat ($urandom_range(55, 70)) tick();
      end else begin
        if (r < 30) p = $urandom_range(4, 45);
        else p = nom($urandom_range(0, 7)) + int'($urandom_range(0, 2)) - 1;
        n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++) drive_period(p, $urandom_range(1, p - 1));
      end
    end

    repeat (10) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
